// File: rtl/lcd_wave_display.sv
// lcd_wave_display: 800x480 LCD pixel generator. Captures ADC samples into a
// 512x8 buffer and draws them as a trace. Also draws two touch buttons
// (capture / freeze) and eight BCD digits as 7-segment glyphs.
// Optional build macro: WAVE_GRID_EN adds a 64x32 px grid inside the wave area.
module lcd_wave_display #(
  parameter int unsigned WAVE_X = 100,
  parameter int unsigned WAVE_Y = 42,
  parameter int unsigned H_RES  = 800,
  parameter int unsigned V_RES  = 480
) (
  input  logic        lcd_pclk,
  input  logic        sys_rst,
  input  logic [7:0]  ad_data,
  input  logic        ad_clk,
  input  logic [31:0] data_in,
  input  logic [31:0] bcd_data,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  output logic [23:0] pixel_data,
  output logic [31:0] data_out
);

  // Geometry, pre-sized to the 11-bit pixel coordinate width
  localparam logic [10:0] X0     = 11'(WAVE_X);
  localparam logic [10:0] Y0     = 11'(WAVE_Y);
  localparam logic [10:0] X_LAST = 11'(WAVE_X + 511);
  localparam logic [10:0] Y_LAST = 11'(WAVE_Y + 255);
  localparam logic [10:0] XB_L   = 11'(WAVE_X - 1);
  localparam logic [10:0] XB_R   = 11'(WAVE_X + 512);
  localparam logic [10:0] YB_T   = 11'(WAVE_Y - 1);
  localparam logic [10:0] YB_B   = 11'(WAVE_Y + 256);
  localparam logic [10:0] HRES   = 11'(H_RES);
  localparam logic [10:0] VRES   = 11'(V_RES);
  localparam logic [10:0] BTN_Y0 = 11'd390;
  localparam logic [10:0] BTN_Y1 = 11'd429;
  localparam logic [10:0] B1_X0  = 11'd100;
  localparam logic [10:0] B1_X1  = 11'd199;
  localparam logic [10:0] B2_X0  = 11'd300;
  localparam logic [10:0] B2_X1  = 11'd399;
  localparam logic [10:0] DIG_Y0 = 11'd320;
  localparam logic [10:0] DIG_Y1 = 11'd351;

  // Colours
  localparam logic [23:0] C_BLACK  = 24'h000000;
  localparam logic [23:0] C_WHITE  = 24'hFFFFFF;
  localparam logic [23:0] C_TRACE  = 24'hFFFF00;
  localparam logic [23:0] C_BG     = 24'h000040;
  localparam logic [23:0] C_B1_ON  = 24'h00FF00;
  localparam logic [23:0] C_B1_OFF = 24'h008000;
  localparam logic [23:0] C_B2_ON  = 24'hFF0000;
  localparam logic [23:0] C_B2_OFF = 24'h800000;
  localparam logic [23:0] C_DIGIT  = 24'h00FFFF;

  // Capture / touch state
  logic        ad_clk_s1_reg, ad_clk_s2_reg, ad_clk_prev_reg;
  logic [7:0]  ad_data_d1_reg, ad_data_d2_reg;
  logic        touch_prev_reg;
  logic        mode_reg, mode_next;            // 1 = WRITE (capture), 0 = READ (freeze)
  logic [8:0]  wr_ptr_reg, wr_ptr_next;
  logic [7:0]  last_sample_reg, last_sample_next;
  logic        wr_en;
  logic [23:0] pixel_data_reg, pixel_data_next;
  logic [31:0] data_out_reg;

  logic        ad_rise, touch_event;
  logic [10:0] touch_x, touch_y;
  logic        touch_btn1, touch_btn2;

  // Sample buffer: one write port, asynchronous read port
  logic [7:0]  ram_mem [0:511];
  logic [8:0]  rd_addr;
  logic [7:0]  rd_sample;

  // Synchroniser, edge detectors and control registers
  always_ff @(posedge lcd_pclk) begin
    if (sys_rst) begin
      ad_clk_s1_reg   <= 1'b0;
      ad_clk_s2_reg   <= 1'b0;
      ad_clk_prev_reg <= 1'b0;
      ad_data_d1_reg  <= 8'd0;
      ad_data_d2_reg  <= 8'd0;
      touch_prev_reg  <= 1'b0;
      mode_reg        <= 1'b0;
      wr_ptr_reg      <= 9'd0;
      last_sample_reg <= 8'd0;
      pixel_data_reg  <= 24'd0;
      data_out_reg    <= 32'd0;
    end else begin
      ad_clk_s1_reg   <= ad_clk;
      ad_clk_s2_reg   <= ad_clk_s1_reg;
      ad_clk_prev_reg <= ad_clk_s2_reg;
      ad_data_d1_reg  <= ad_data;
      ad_data_d2_reg  <= ad_data_d1_reg;
      touch_prev_reg  <= |data_in;
      mode_reg        <= mode_next;
      wr_ptr_reg      <= wr_ptr_next;
      last_sample_reg <= last_sample_next;
      pixel_data_reg  <= pixel_data_next;
      data_out_reg    <= {mode_next, 7'b0, last_sample_next, 7'b0, wr_ptr_next};
    end
  end

  // Mode / write-pointer control; a touch event pre-empts a coincident write
  always_comb begin
    mode_next        = mode_reg;
    wr_ptr_next      = wr_ptr_reg;
    last_sample_next = last_sample_reg;
    wr_en            = 1'b0;
    ad_rise          = ad_clk_s2_reg & ~ad_clk_prev_reg;
    touch_event      = (|data_in) & ~touch_prev_reg;
    touch_x          = data_in[26:16];
    touch_y          = data_in[10:0];
    touch_btn1       = (touch_x >= B1_X0) && (touch_x <= B1_X1) &&
                       (touch_y >= BTN_Y0) && (touch_y <= BTN_Y1);
    touch_btn2       = (touch_x >= B2_X0) && (touch_x <= B2_X1) &&
                       (touch_y >= BTN_Y0) && (touch_y <= BTN_Y1);
    if (touch_event) begin
      if (touch_btn1) begin
        mode_next   = 1'b1;
        wr_ptr_next = 9'd0;
      end else if (touch_btn2) begin
        mode_next   = 1'b0;
      end
    end else if (ad_rise && mode_reg) begin
      wr_en            = 1'b1;
      wr_ptr_next      = wr_ptr_reg + 9'd1;
      last_sample_next = ad_data_d2_reg;
    end
  end

  // Buffer write; a same-cycle read still sees the old word
  always_ff @(posedge lcd_pclk) begin
    if (wr_en) begin
      ram_mem[wr_ptr_reg] <= ad_data_d2_reg;
    end
  end

  assign rd_addr   = pixel_xpos[8:0] - X0[8:0];
  assign rd_sample = ram_mem[rd_addr];

  // Per-digit 7-segment hit detection
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    // bit order {a,b,c,d,e,f,g}
    case (nib)
      4'd0:    seg_decode = 7'b1111110;
      4'd1:    seg_decode = 7'b0110000;
      4'd2:    seg_decode = 7'b1101101;
      4'd3:    seg_decode = 7'b1111001;
      4'd4:    seg_decode = 7'b0110011;
      4'd5:    seg_decode = 7'b1011011;
      4'd6:    seg_decode = 7'b1011111;
      4'd7:    seg_decode = 7'b1110000;
      4'd8:    seg_decode = 7'b1111111;
      4'd9:    seg_decode = 7'b1111011;
      default: seg_decode = 7'b0000000;
    endcase
  endfunction

  logic [7:0] digit_on;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      localparam logic [10:0] CELL_X0 = 11'(WAVE_X + 24 * gi);
      localparam logic [10:0] CELL_X1 = 11'(WAVE_X + 24 * gi + 15);
      logic       in_cell;
      logic [3:0] cx;
      logic [4:0] cy;
      logic [6:0] segs;
      logic       top, bot, mid, left, right, upper;

      assign in_cell = (pixel_xpos >= CELL_X0) && (pixel_xpos <= CELL_X1) &&
                       (pixel_ypos >= DIG_Y0) && (pixel_ypos <= DIG_Y1);
      assign cx    = pixel_xpos[3:0] - CELL_X0[3:0];
      assign cy    = pixel_ypos[4:0] - DIG_Y0[4:0];
      assign segs  = seg_decode(bcd_data[31 - 4 * gi -: 4]);
      assign top   = (cy <= 5'd2);
      assign bot   = (cy >= 5'd29);
      assign mid   = (cy >= 5'd14) && (cy <= 5'd16);
      assign left  = (cx <= 4'd2);
      assign right = (cx >= 4'd13);
      assign upper = (cy <= 5'd15);
      assign digit_on[gi] = in_cell & (
          (segs[6] & top) | (segs[5] & right & upper) | (segs[4] & right & ~upper) |
          (segs[3] & bot) | (segs[2] & left & ~upper) | (segs[1] & left & upper) |
          (segs[0] & mid));
    end
  endgenerate

  // Pixel colour selection in priority order
  always_comb begin
    pixel_data_next = C_BLACK;
    if ((pixel_xpos >= HRES) || (pixel_ypos >= VRES)) begin
      pixel_data_next = C_BLACK;
    end else if ((pixel_xpos >= XB_L) && (pixel_xpos <= XB_R) &&
                 (pixel_ypos >= YB_T) && (pixel_ypos <= YB_B)) begin
      if ((pixel_xpos == XB_L) || (pixel_xpos == XB_R) ||
          (pixel_ypos == YB_T) || (pixel_ypos == YB_B)) begin
        pixel_data_next = C_WHITE;
      end else if ((pixel_ypos[7:0] - Y0[7:0]) == ~rd_sample) begin
        // row offset from the top equals 255 - sample
        pixel_data_next = C_TRACE;
`ifdef WAVE_GRID_EN
      end else if (((pixel_xpos[5:0] - X0[5:0]) == 6'd0) ||
                   ((pixel_ypos[4:0] - Y0[4:0]) == 5'd0)) begin
        pixel_data_next = 24'h404040;
`endif
      end else begin
        pixel_data_next = C_BG;
      end
    end else if ((pixel_xpos >= B1_X0) && (pixel_xpos <= B1_X1) &&
                 (pixel_ypos >= BTN_Y0) && (pixel_ypos <= BTN_Y1)) begin
      pixel_data_next = mode_reg ? C_B1_ON : C_B1_OFF;
    end else if ((pixel_xpos >= B2_X0) && (pixel_xpos <= B2_X1) &&
                 (pixel_ypos >= BTN_Y0) && (pixel_ypos <= BTN_Y1)) begin
      pixel_data_next = mode_reg ? C_B2_OFF : C_B2_ON;
    end else if (|digit_on) begin
      pixel_data_next = C_DIGIT;
    end
  end

  assign pixel_data = pixel_data_reg;
  assign data_out   = data_out_reg;

  // Unused-in-practice geometry bounds kept for readability of the wave box
  logic unused_bounds;
  assign unused_bounds = ^{X_LAST, Y_LAST};

endmodule

// File: tb/tb_lcd_wave_display.sv
// tb_lcd_wave_display: self-checking bench for lcd_wave_display.
// Pixel expectations go through a scoreboard queue checked one clock later;
// status-word expectations come from a small behavioural model.
module tb_lcd_wave_display;

  logic        lcd_pclk = 1'b0;
  logic        sys_rst;
  logic [7:0]  ad_data;
  logic        ad_clk;
  logic [31:0] data_in;
  logic [31:0] bcd_data;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic [23:0] pixel_data;
  logic [31:0] data_out;

  lcd_wave_display dut (
    .lcd_pclk   (lcd_pclk),
    .sys_rst    (sys_rst),
    .ad_data    (ad_data),
    .ad_clk     (ad_clk),
    .data_in    (data_in),
    .bcd_data   (bcd_data),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .pixel_data (pixel_data),
    .data_out   (data_out)
  );

  always #5 lcd_pclk = ~lcd_pclk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [7:0] mem_model [512];
  logic       mode_model = 1'b0;
  logic [8:0] ptr_model  = 9'd0;
  logic [7:0] last_model = 8'd0;

  typedef struct {
    int          x;
    int          y;
    logic [23:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs[13];

  // Scoreboard checker: one pixel result per clock, one clock after drive
  always @(posedge lcd_pclk) begin
    sb_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total++;
      if (pixel_data !== e.exp) begin
        bad++;
        $display("FAIL pixel(%0d,%0d): got %06h want %06h", e.x, e.y, pixel_data, e.exp);
      end
    end
  end

  function automatic bit digit_lit(input logic [3:0] n, input int cx, input int cy);
    logic [6:0] s;
    bit top, bot, mid, left, right, up;
    case (n)
      4'd0: s = 7'b1111110;  4'd1: s = 7'b0110000;
      4'd2: s = 7'b1101101;  4'd3: s = 7'b1111001;
      4'd4: s = 7'b0110011;  4'd5: s = 7'b1011011;
      4'd6: s = 7'b1011111;  4'd7: s = 7'b1110000;
      4'd8: s = 7'b1111111;  4'd9: s = 7'b1111011;
      default: s = 7'b0;
    endcase
    top = cy < 3;  bot = cy > 28;  mid = (cy > 13) && (cy < 17);
    left = cx < 3; right = cx > 12; up = cy < 16;
    return (s[6] && top) || (s[5] && right && up) || (s[4] && right && !up) ||
           (s[3] && bot) || (s[2] && left && !up) || (s[1] && left && up) || (s[0] && mid);
  endfunction

  function automatic logic [23:0] exp_pix(input int x, input int y);
    int s, d, cx;
    logic [3:0] nib;
    if (x >= 800 || y >= 480) return 24'h000000;
    if (x >= 99 && x <= 612 && y >= 41 && y <= 298) begin
      if (x == 99 || x == 612 || y == 41 || y == 298) return 24'hFFFFFF;
      s = int'(mem_model[x - 100]);
      if (y - 42 == 255 - s) return 24'hFFFF00;
`ifdef WAVE_GRID_EN
      if ((x - 100) % 64 == 0 || (y - 42) % 32 == 0) return 24'h404040;
`endif
      return 24'h000040;
    end
    if (x >= 100 && x <= 199 && y >= 390 && y <= 429) return mode_model ? 24'h00FF00 : 24'h008000;
    if (x >= 300 && x <= 399 && y >= 390 && y <= 429) return mode_model ? 24'h800000 : 24'hFF0000;
    if (x >= 100 && y >= 320 && y <= 351) begin
      d  = (x - 100) / 24;
      cx = (x - 100) % 24;
      if (d < 8 && cx < 16) begin
        nib = bcd_data[31 - 4 * d -: 4];
        if (digit_lit(nib, cx, y - 320)) return 24'h00FFFF;
      end
    end
    return 24'h000000;
  endfunction

  task automatic drive_pix(input int x, input int y, input logic [23:0] e);
    @(negedge lcd_pclk);
    pixel_xpos = 11'(x);
    pixel_ypos = 11'(y);
    sb_q.push_back('{x, y, e});
  endtask

  task automatic drain();
    @(posedge lcd_pclk);
    #2;
  endtask

  task automatic check_dout(input string name, input logic [31:0] e);
    repeat (3) @(negedge lcd_pclk);
    total++;
    if (data_out !== e) begin
      bad++;
      $display("FAIL %s: data_out got %08h want %08h", name, data_out, e);
    end
  endtask

  function automatic logic [31:0] model_dout();
    return {mode_model, 7'b0, last_model, 7'b0, ptr_model};
  endfunction

  task automatic touch(input int x, input int y);
    @(negedge lcd_pclk);
    data_in = {5'd0, 11'(x), 5'd0, 11'(y)};
    if (x >= 100 && x <= 199 && y >= 390 && y <= 429) begin
      mode_model = 1'b1;
      ptr_model  = 9'd0;
    end else if (x >= 300 && x <= 399 && y >= 390 && y <= 429) begin
      mode_model = 1'b0;
    end
  endtask

  task automatic release_touch();
    @(negedge lcd_pclk);
    data_in = 32'd0;
    repeat (2) @(negedge lcd_pclk);
  endtask

  task automatic ad_edge(input logic [7:0] v);
    @(negedge lcd_pclk);
    ad_data = v;
    ad_clk  = 1'b1;
    repeat (3) @(negedge lcd_pclk);
    ad_clk = 1'b0;
    repeat (3) @(negedge lcd_pclk);
    if (mode_model) begin
      mem_model[ptr_model] = v;
      ptr_model  = ptr_model + 9'd1;
      last_model = v;
    end
  endtask

  initial begin
    logic [7:0] sv;
    vecs[0]  = '{11'd150, 11'd410, 24'h008000};
    vecs[1]  = '{11'd350, 11'd410, 24'hFF0000};
    vecs[2]  = '{11'd800, 11'd0,   24'h000000};
    vecs[3]  = '{11'd0,   11'd480, 24'h000000};
    vecs[4]  = '{11'd99,  11'd100, 24'hFFFFFF};
    vecs[5]  = '{11'd612, 11'd100, 24'hFFFFFF};
    vecs[6]  = '{11'd300, 11'd41,  24'hFFFFFF};
    vecs[7]  = '{11'd300, 11'd298, 24'hFFFFFF};
    vecs[8]  = '{11'd50,  11'd50,  24'h000000};
    vecs[9]  = '{11'd799, 11'd479, 24'h000000};
    vecs[10] = '{11'd199, 11'd429, 24'h008000};
    vecs[11] = '{11'd200, 11'd410, 24'h000000};
    vecs[12] = '{11'd300, 11'd390, 24'hFF0000};

    // Test 1: reset, then static pixels from the table
    sys_rst = 1'b1; ad_clk = 1'b0; ad_data = 8'd0; data_in = 32'd0;
    bcd_data = 32'hFFFF_FFFF; pixel_xpos = 11'd150; pixel_ypos = 11'd410;
    repeat (3) @(posedge lcd_pclk);
    #1;
    total++;
    if (pixel_data !== 24'd0) begin
      bad++; $display("FAIL reset_pixel: got %06h want 000000", pixel_data);
    end
    total++;
    if (data_out !== 32'd0) begin
      bad++; $display("FAIL reset_dout: got %08h want 00000000", data_out);
    end
    @(negedge lcd_pclk);
    sys_rst = 1'b0;
    for (int i = 0; i < 13; i++) drive_pix(int'(vecs[i].x), int'(vecs[i].y), vecs[i].exp);
    drain();

    // Test 2: capture mode, held touch does not re-arm, 64 samples
    touch(150, 410);
    check_dout("enter_write", 32'h8000_0000);
    drive_pix(150, 410, 24'h00FF00);
    drive_pix(350, 410, 24'h800000);
    drain();
    for (int k = 0; k < 64; k++) ad_edge(8'h80);
    check_dout("write_64", model_dout());

    // Touch event and ADC edge in the same cycle: touch wins, no write
    release_touch();
    @(negedge lcd_pclk);
    ad_data = 8'h55;
    ad_clk  = 1'b1;
    @(posedge lcd_pclk);
    @(posedge lcd_pclk);
    @(negedge lcd_pclk);
    data_in = {5'd0, 11'd150, 5'd0, 11'd410};
    mode_model = 1'b1;
    ptr_model  = 9'd0;
    repeat (3) @(negedge lcd_pclk);
    ad_clk = 1'b0;
    check_dout("touch_beats_write", {1'b1, 7'b0, 8'h80, 7'b0, 9'd0});

    // Test 3: 512 sine then 512 triangle samples, pointer wrap
    for (int k = 0; k < 512; k++) begin
      sv = 8'(int'(127.0 + 127.0 * $sin(6.2831853 * real'(k) / 512.0)));
      ad_edge(sv);
      if (k == 510) check_dout("ptr_511", {1'b1, 7'b0, sv, 7'b0, 9'd511});
    end
    check_dout("ptr_wrap_sine", model_dout());
    for (int k = 0; k < 512; k++) ad_edge(k < 256 ? 8'(k) : 8'(511 - k));
    check_dout("ptr_wrap_tri", {1'b1, 7'b0, 8'd0, 7'b0, 9'd0});

    // Test 4: freeze via held touch on button 2; further edges ignored
    release_touch();
    touch(350, 410);
    check_dout("enter_read", {1'b0, 7'b0, 8'd0, 7'b0, 9'd0});
    for (int k = 0; k < 4; k++) ad_edge(8'h33);
    check_dout("read_no_write", {1'b0, 7'b0, 8'd0, 7'b0, 9'd0});
    release_touch();

    // Test 5: trace pixels and neighbours in every column, plus sparse full columns
    for (int x = 100; x < 612; x++) begin
      int ty;
      ty = 42 + 255 - (x < 356 ? (x - 100) : (611 - x));
      drive_pix(x, ty, 24'hFFFF00);
      drive_pix(x, ty - 1, exp_pix(x, ty - 1));
      drive_pix(x, ty + 1, exp_pix(x, ty + 1));
    end
    for (int x = 100; x < 612; x += 16)
      for (int y = 41; y <= 298; y++) drive_pix(x, y, exp_pix(x, y));
    drain();

    // Test 6: digit glyphs, including blank nibbles
    bcd_data = 32'h0012_3456;
    for (int y = 318; y <= 353; y++)
      for (int x = 96; x <= 296; x++) drive_pix(x, y, exp_pix(x, y));
    drive_pix(800, 0, 24'h000000);
    drive_pix(276, 321, 24'h00FFFF);   // digit 7 '6', segment a
    drive_pix(276, 335, 24'h00FFFF);   // digit 7 '6', segment g
    drain();
    @(negedge lcd_pclk);
    bcd_data = 32'hFA00_0000;
    drive_pix(108, 321, 24'h000000);   // nibble F blank
    drive_pix(132, 321, 24'h000000);   // nibble A blank
    drive_pix(156, 321, 24'h00FFFF);   // '0' segment a
    drive_pix(156, 335, 24'h000000);   // '0' has no segment g
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
